// File: rtl/databus_axi_pkg.sv
// databus_axi_pkg: AXI constants, adapter state encoding and arsize helper.
package databus_axi_pkg;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  function automatic logic [2:0] arsize_f(input int data_w);
    logic [2:0] s;
    s = '0;
    for (int b = data_w / 8; b > 1; b = b / 2) s = s + 3'd1;
    return s;
  endfunction
endpackage

// File: rtl/databus_axi_read_if.sv
// databus_axi_read_if: databus request/beat port plus AXI AR/R channels of the read adapter.
interface databus_axi_read_if #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int LEN_W = 8
);
  logic databus_valid;
  logic databus_ready;
  logic [AXI_ADDR_W-1:0] databus_addr;
  logic [LEN_W-1:0] databus_len;
  logic [AXI_DATA_W-1:0] databus_rdata;
  logic databus_last;
  logic [AXI_ADDR_W-1:0] m_axi_araddr;
  logic [LEN_W-1:0] m_axi_arlen;
  logic [2:0] m_axi_arsize;
  logic [1:0] m_axi_arburst;
  logic m_axi_arvalid;
  logic m_axi_arready;
  logic [AXI_DATA_W-1:0] m_axi_rdata;
  logic [1:0] m_axi_rresp;
  logic m_axi_rlast;
  logic m_axi_rvalid;
  logic m_axi_rready;
  modport master (
    input databus_valid, databus_addr, databus_len, m_axi_arready, m_axi_rdata, m_axi_rresp,
          m_axi_rlast, m_axi_rvalid,
    output databus_ready, databus_rdata, databus_last, m_axi_araddr, m_axi_arlen, m_axi_arsize,
           m_axi_arburst, m_axi_arvalid, m_axi_rready
  );
  modport slave (
    output databus_valid, databus_addr, databus_len, m_axi_arready, m_axi_rdata, m_axi_rresp,
           m_axi_rlast, m_axi_rvalid,
    input databus_ready, databus_rdata, databus_last, m_axi_araddr, m_axi_arlen, m_axi_arsize,
          m_axi_arburst, m_axi_arvalid, m_axi_rready
  );
endinterface

// File: rtl/axi_r_skid.sv
// axi_r_skid: 2-entry valid/ready skid buffer; in_ready comes straight from the occupancy register.
module axi_r_skid #(
  parameter int W = 35
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  logic [W-1:0] in_data,
  output logic out_valid,
  input  logic out_ready,
  output logic [W-1:0] out_data
);
  logic [W-1:0] mem [2];
  logic wp, rp, push, pop;
  logic [1:0] cnt;
  assign in_ready = ~cnt[1];
  assign out_valid = |cnt;
  assign out_data = mem[rp];
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= '0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= '0;
    end else begin
      if (push) mem[wp] <= in_data;
      if (push) wp <= ~wp;
      if (pop) rp <= ~rp;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
endmodule

// File: rtl/databus_axi_read.sv
// databus_axi_read: turns one databus read request into a single AXI4 INCR burst and streams R beats back.
// Define DATABUS_AXI_READ_R_SLICE_EN to register the R path through a 2-entry skid buffer.
module databus_axi_read
  import databus_axi_pkg::*;
#(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int LEN_W = 8
) (
  input  logic clk,
  input  logic rst,
  databus_axi_read_if.master bus,
  output logic busy,
  output logic error
);
  state_t state;
  logic arvalid, in_data, beat, last_now, b_valid, b_last;
  logic [AXI_ADDR_W-1:0] araddr;
  logic [LEN_W-1:0] arlen, cnt;
  logic [1:0] b_resp;
  logic [AXI_DATA_W-1:0] b_data;
  assign in_data = state == DATA;
`ifdef DATABUS_AXI_READ_R_SLICE_EN
  logic skid_ready;
  axi_r_skid #(.W(AXI_DATA_W + 3)) u_skid (
    .clk(clk),
    .rst(rst),
    .flush(!in_data),
    .in_valid(bus.m_axi_rvalid & in_data),
    .in_ready(skid_ready),
    .in_data({bus.m_axi_rdata, bus.m_axi_rresp, bus.m_axi_rlast}),
    .out_valid(b_valid),
    .out_ready(bus.databus_valid & in_data),
    .out_data({b_data, b_resp, b_last})
  );
  assign bus.m_axi_rready = in_data & skid_ready;
`else
  assign b_valid = bus.m_axi_rvalid;
  assign b_data = bus.m_axi_rdata;
  assign b_resp = bus.m_axi_rresp;
  assign b_last = bus.m_axi_rlast;
  assign bus.m_axi_rready = in_data & bus.databus_valid;
`endif
  // An exhausted counter ends the burst even if the slave never raises rlast.
  assign last_now = b_last | ~|cnt;
  assign beat = in_data & b_valid & bus.databus_valid;
  assign bus.databus_ready = in_data & b_valid;
  assign bus.databus_rdata = b_data;
  assign bus.databus_last = in_data & b_valid & last_now;
  assign bus.m_axi_araddr = araddr;
  assign bus.m_axi_arlen = arlen;
  assign bus.m_axi_arsize = arsize_f(AXI_DATA_W);
  assign bus.m_axi_arburst = AXI_BURST_INCR;
  assign bus.m_axi_arvalid = arvalid;
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      arvalid <= 1'b0;
      araddr <= '0;
      arlen <= '0;
      cnt <= '0;
      error <= 1'b0;
    end else
      case (state)
        IDLE: if (bus.databus_valid) begin
          state <= ADDR;
          arvalid <= 1'b1;
          araddr <= bus.databus_addr;
          arlen <= bus.databus_len;
          cnt <= bus.databus_len;
          error <= 1'b0;
        end
        ADDR: if (bus.m_axi_arready) begin
          state <= DATA;
          arvalid <= 1'b0;
        end
        DATA: if (beat) begin
          cnt <= cnt - LEN_W'(1);
          if (b_resp != AXI_RESP_OKAY || b_last != ~|cnt) error <= 1'b1;
          if (last_now) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_databus_axi_read.sv
// tb_databus_axi_read: table-driven and randomized bursts against a spec-level slave/unit model.
module tb_databus_axi_read;
  localparam int AW = 32, DW = 32, LW = 8;
`ifdef DATABUS_AXI_READ_R_SLICE_EN
  localparam int SLICE = 1;
`else
  localparam int SLICE = 0;
`endif
  logic clk = 1'b0, rst = 1'b1, busy, error;
  int checks = 0, failures = 0;
  databus_axi_read_if #(.AXI_ADDR_W(AW), .AXI_DATA_W(DW), .LEN_W(LW)) bus ();
  databus_axi_read #(.AXI_ADDR_W(AW), .AXI_DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .error(error)
  );
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int len, ar_delay, rv_prob, dv_prob, err_beat, early_last, stall_at;
    bit no_last, exp_err;
    int exp_beats;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a, input int i);
    return a ^ (32'(i) * 32'h9E3779B9) ^ 32'h5A5A_0000;
  endfunction

  task automatic run_burst(input vec_t v);
    int cyc = 0, aw = 0, bi = 0, occ = 0, ar_n = 0, ar_cyc = -1, dr_cyc = -1, stall = 0, got = 0;
    int slave_n, budget, data_bad = 0, last_bad = 0, rr_viol = 0, sticky_viol = 0;
    bit ar_done = 0, done = 0, was_done, fin = 0, prev_err = 0, in_data, r_hs, d_hs, rv_hold = 0, exp_rr;
    logic [31:0] a_addr = '0;
    logic [7:0] a_len = '0;
    logic [2:0] a_size = '0;
    logic [1:0] a_burst = '0;
    slave_n = v.early_last >= 0 ? v.early_last + 1 : v.len + 1;
    budget = 40 * (v.len + 1) + 100;
    @(posedge clk); #1;
    bus.databus_addr = v.addr;
    bus.databus_len = 8'(v.len);
    bus.databus_valid = 1'b1;
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rvalid = 1'b0;
    while (!fin && cyc < budget) begin
      in_data = ar_done && !done;
      was_done = done;
      if (cyc > 0) begin
        bus.m_axi_arready = bus.m_axi_arvalid && aw >= v.ar_delay;
        if (bus.m_axi_arvalid) aw++;
        if (!in_data || bi >= slave_n) bus.m_axi_rvalid = 1'b0;
        else if (!rv_hold) bus.m_axi_rvalid = $urandom_range(99) < v.rv_prob;
        bus.m_axi_rdata = word(v.addr, bi);
        bus.m_axi_rresp = bi == v.err_beat ? 2'b10 : 2'b00;
        bus.m_axi_rlast = !v.no_last && bi == slave_n - 1;
        if (!in_data) bus.databus_valid = 1'b0;
        else if (v.stall_at >= 0 && got == v.stall_at && stall < 3) begin
          bus.databus_valid = 1'b0;
          stall++;
        end else bus.databus_valid = $urandom_range(99) < v.dv_prob;
      end
      @(negedge clk);
      r_hs = bus.m_axi_rvalid && bus.m_axi_rready;
      d_hs = bus.databus_valid && bus.databus_ready;
      exp_rr = in_data && (SLICE != 0 ? occ < 2 : bus.databus_valid);
      if (bus.m_axi_rready !== exp_rr) rr_viol++;
      if (bus.m_axi_arvalid && bus.m_axi_arready) begin
        ar_n++;
        a_addr = bus.m_axi_araddr;
        a_len = bus.m_axi_arlen;
        a_size = bus.m_axi_arsize;
        a_burst = bus.m_axi_arburst;
        ar_cyc = cyc;
        ar_done = 1;
      end
      if (in_data && bus.databus_ready && dr_cyc < 0) dr_cyc = cyc;
      if (d_hs) begin
        if (got >= v.exp_beats || bus.databus_rdata !== word(v.addr, got)) data_bad++;
        if (bus.databus_last !== (got == v.exp_beats - 1)) last_bad++;
        got++;
        if (bus.databus_last) done = 1;
      end
      if (r_hs) bi++;
      occ += int'(r_hs) - int'(d_hs);
      rv_hold = bus.m_axi_rvalid && !r_hs;
      if (cyc == 1) chk("err_clear_on_request", error, 0);
      if (cyc >= 2 && prev_err && !error) sticky_viol++;
      prev_err = error;
      if (was_done) begin
        chk("busy_after_last", busy, 0);
        fin = 1;
      end
      cyc++;
      if (!fin) begin
        @(posedge clk); #1;
      end
    end
    if (!fin) begin
      checks++;
      failures++;
      $display("FAIL timeout: burst addr=%0h unfinished after %0d cycles, required finish", v.addr, cyc);
      rst = 1'b1;
      #1 rst = 1'b0;
    end
    bus.m_axi_rvalid = 1'b0;
    bus.databus_valid = 1'b0;
    bus.m_axi_arready = 1'b0;
    chk("ar_count", ar_n, 1);
    chk("araddr", a_addr, v.addr);
    chk("arlen", a_len, v.len);
    chk("arsize", a_size, 2);
    chk("arburst", a_burst, 1);
    chk("beat_count", got, v.exp_beats);
    chk("beat_data_errors", data_bad, 0);
    chk("beat_last_errors", last_bad, 0);
    chk("error_flag", error, v.exp_err);
    chk("error_sticky_drops", sticky_viol, 0);
    chk("rready_errors", rr_viol, 0);
    if (v.rv_prob == 100) chk("first_beat_latency", dr_cyc - ar_cyc, 1 + SLICE);
  endtask

  vec_t tbl[8];
  vec_t r;

  initial begin
    bus.databus_valid = 1'b0;
    bus.databus_addr = '0;
    bus.databus_len = '0;
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rdata = '0;
    bus.m_axi_rresp = 2'b00;
    bus.m_axi_rlast = 1'b0;
    bus.m_axi_rvalid = 1'b0;
    // fields: addr len ar_delay rv dv err_beat early_last stall_at no_last exp_err exp_beats
    tbl[0] = '{32'h1000, 3, 2, 100, 100, -1, -1, -1, 0, 0, 4};
    tbl[1] = '{32'h2000, 0, 0, 100, 100, -1, -1, -1, 0, 0, 1};
    tbl[2] = '{32'h2040, 0, 0, 100, 100, -1, -1, -1, 0, 0, 1};
    tbl[3] = '{32'h3000, 7, 1, 100, 100, -1, -1, 3, 0, 0, 8};
    tbl[4] = '{32'h4000, 3, 0, 100, 100, 1, -1, -1, 0, 1, 4};
    tbl[5] = '{32'h5000, 3, 0, 100, 100, -1, 1, -1, 0, 1, 2};
    tbl[6] = '{32'h6000, 1, 3, 100, 100, -1, -1, -1, 1, 1, 2};
    tbl[7] = '{32'h7000, 255, 1, 70, 70, -1, -1, -1, 0, 0, 256};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    chk("rst_arvalid", bus.m_axi_arvalid, 0);
    chk("rst_araddr", bus.m_axi_araddr, 0);
    chk("rst_arlen", bus.m_axi_arlen, 0);
    chk("rst_databus_ready", bus.databus_ready, 0);
    chk("rst_databus_last", bus.databus_last, 0);
    chk("rst_rready", bus.m_axi_rready, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) run_burst(tbl[i]);
    for (int i = 0; i < 8; i++) begin
      r.addr = 32'(i) << 12 | 32'h8_0000;
      r.len = $urandom_range(20);
      r.ar_delay = $urandom_range(3);
      r.rv_prob = i == 0 ? 100 : $urandom_range(100, 30);
      r.dv_prob = $urandom_range(100, 30);
      r.err_beat = $urandom_range(2) == 0 ? $urandom_range(r.len) : -1;
      r.early_last = ($urandom_range(3) == 0 && r.len > 0) ? $urandom_range(r.len - 1) : -1;
      r.stall_at = -1;
      r.no_last = 0;
      r.exp_beats = r.early_last >= 0 ? r.early_last + 1 : r.len + 1;
      r.exp_err = r.early_last >= 0 || (r.err_beat >= 0 && r.err_beat < r.exp_beats);
      run_burst(r);
    end
    // Reset in the middle of a burst must return every output to its reset value at once.
    @(posedge clk); #1;
    bus.databus_addr = 32'h9000;
    bus.databus_len = 8'd15;
    bus.databus_valid = 1'b1;
    bus.m_axi_arready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.m_axi_rvalid = 1'b1;
    bus.m_axi_rresp = 2'b10;
    bus.m_axi_rlast = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("mid_burst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_error", error, 0);
    chk("midrst_arvalid", bus.m_axi_arvalid, 0);
    chk("midrst_rready", bus.m_axi_rready, 0);
    chk("midrst_databus_ready", bus.databus_ready, 0);
    chk("midrst_databus_last", bus.databus_last, 0);
    bus.m_axi_rvalid = 1'b0;
    bus.m_axi_rresp = 2'b00;
    bus.databus_valid = 1'b0;
    bus.m_axi_arready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_burst(tbl[0]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
